// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter and sequencer that shares one uarttx
//                transmitter among NUM_REQ byte producers. It accepts one
//                byte, starts the transmitter, waits for frame completion
//                (or a timeout) and reports back to the owning requester.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1250,
    localparam int ID_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int TMR_W         = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   req_done,
    output logic                 newd,
    output logic [7:0]           datatx,
    input  logic                 donetx,
    output logic [ID_W-1:0]      grant_id,
    output logic                 busy,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_DONE = 2'd1,
        ST_GAP       = 2'd2
    } state_t;

    localparam logic [TMR_W-1:0]   C_TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0]    C_LAST_RST = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W:0]      C_NUM_REQ  = (ID_W+1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] C_ONE      = NUM_REQ'(1);

    state_t             r_state;
    state_t             w_state_next;
    logic [ID_W-1:0]    r_last_grant;
    logic [TMR_W-1:0]   r_timer;

    logic               w_found;
    logic [ID_W-1:0]    w_pick;
    logic [ID_W:0]      w_idx;

    logic [NUM_REQ-1:0] w_ready_next;
    logic [NUM_REQ-1:0] w_done_next;
    logic               w_newd_next;
    logic               w_timeout_next;
    logic [7:0]         w_data_next;
    logic [ID_W-1:0]    w_gid_next;
    logic [ID_W-1:0]    w_last_next;
    logic [TMR_W-1:0]   w_timer_next;

    // Round-robin search: first pending requester after the last granted one.
    always_comb begin : arb_search
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx = {1'b0, r_last_grant} + (ID_W+1)'(off);
            if (w_idx >= C_NUM_REQ) begin
                w_idx = w_idx - C_NUM_REQ;
            end
            if (!w_found && req_valid[w_idx[ID_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[ID_W-1:0];
            end
        end
    end

    // Next state and next values of every registered output.
    always_comb begin : fsm_next
        w_state_next   = r_state;
        w_ready_next   = '0;
        w_done_next    = '0;
        w_newd_next    = 1'b0;
        w_timeout_next = 1'b0;
        w_data_next    = datatx;
        w_gid_next     = grant_id;
        w_last_next    = r_last_grant;
        w_timer_next   = r_timer;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_ready_next = C_ONE << w_pick;
                    w_newd_next  = 1'b1;
                    w_data_next  = req_data[{w_pick, 3'b000} +: 8];
                    w_gid_next   = w_pick;
                    w_timer_next = '0;
                    w_state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                w_timer_next = r_timer + TMR_W'(1);
                // A completion on the timeout edge is still a completion.
                if (donetx) begin
                    w_done_next  = C_ONE << grant_id;
                    w_last_next  = grant_id;
                    w_state_next = ST_GAP;
                end else if (r_timer == C_TMR_LAST) begin
                    w_timeout_next = 1'b1;
                    w_last_next    = grant_id;
                    w_state_next   = ST_GAP;
                end
            end
            ST_GAP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin : state_reg
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Registered outputs, arbitration pointer and frame timer.
    always_ff @(posedge clk or posedge rst) begin : out_reg
        if (rst) begin
            req_ready    <= '0;
            req_done     <= '0;
            newd         <= 1'b0;
            timeout_err  <= 1'b0;
            busy         <= 1'b0;
            datatx       <= 8'h00;
            grant_id     <= '0;
            r_last_grant <= C_LAST_RST;
            r_timer      <= '0;
        end else begin
            req_ready    <= w_ready_next;
            req_done     <= w_done_next;
            newd         <= w_newd_next;
            timeout_err  <= w_timeout_next;
            busy         <= (w_state_next != ST_IDLE);
            datatx       <= w_data_next;
            grant_id     <= w_gid_next;
            r_last_grant <= w_last_next;
            r_timer      <= w_timer_next;
        end
    end

endmodule
`default_nettype wire
